// File: rtl/fifo_rd_stream_adapter.sv
// Read stage for a 1-cycle-latency sync FIFO: issues safe reads, captures the
// returned words in a 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream_adapter #(
    parameter int WIDTH    = 32,
    parameter int LAST_BIT = -1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_fifo_rd_en,
    input  logic [WIDTH-1:0] i_fifo_dout,
    input  logic             i_fifo_empty,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_busy
);

    localparam int SKID_DEPTH = 2;

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [1:0]       buf_cnt;
    logic             rp;
    logic             wp;
    logic             inflight;
    logic             pop;
    logic [2:0]       level;

    // Occupancy after this edge; a read may only issue if a slot is guaranteed.
    assign pop   = o_valid & i_ready;
    assign level = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

    assign o_fifo_rd_en = ~i_rst & ~i_fifo_empty & (level < 3'(SKID_DEPTH));
    assign o_valid      = (buf_cnt != 2'd0);
    assign o_data       = mem[rp];
    assign o_busy       = o_valid | inflight;

    generate
        if (LAST_BIT >= 0) begin : g_last
            assign o_last = o_data[LAST_BIT];
        end else begin : g_nolast
            assign o_last = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_cnt     <= 2'd0;
            rp          <= 1'b0;
            wp          <= 1'b0;
            inflight    <= 1'b0;
            o_frame_cnt <= '0;
            mem[0]      <= '0;
            mem[1]      <= '0;
        end else begin
            inflight <= o_fifo_rd_en;
            if (inflight) begin
                mem[wp] <= i_fifo_dout;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
                if (o_last) begin
                    o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                end
            end
            buf_cnt <= level[1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            a_no_overflow : assert (buf_cnt <= 2'd2);
            a_no_rd_empty : assert (!(o_fifo_rd_en && i_fifo_empty));
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter with a behavioural 16-deep standard-mode FIFO,
// an outstanding-word scoreboard and directed literal checks.
module tb_fifo_rd_stream_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en;
    logic [31:0] dout = 32'h0;
    logic        empty;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        ready = 1'b0;
    logic [1:0]  fcnt_o;
    logic        busy;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.WIDTH(32), .LAST_BIT(31), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .o_fifo_rd_en(rd_en), .i_fifo_dout(dout),
        .i_fifo_empty(empty), .o_valid(valid), .o_data(data), .o_last(last),
        .i_ready(ready), .o_frame_cnt(fcnt_o), .o_busy(busy)
    );

    // Standard-mode FIFO: data appears on dout the cycle after a read strobe.
    logic [31:0] fm [16];
    int          fwp = 0;
    int          frp = 0;
    int          fcnt = 0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;

    assign empty = (fcnt == 0);

    always @(posedge clk) begin
        if (wr_en) begin
            fm[fwp] <= wr_data;
            fwp     <= (fwp + 1) % 16;
        end
        if (rd_en) begin
            dout <= fm[frp];
            frp  <= (frp + 1) % 16;
        end
        fcnt <= fcnt + int'(wr_en) - int'(rd_en);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words read from the FIFO and not yet accepted downstream.
    logic [31:0] exp_q [$];
    int          outst = 0;
    bit          last_rd = 0;
    int          mcnt = 0;
    bit          pop_s = 0;
    bit          rd_s = 0;
    bit          prev_stall = 0;
    logic [31:0] held = 32'h0;
    bit          ev;
    bit          ep;
    bit          er;
    logic [31:0] head;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_en", rd_en, 0);
            check("rst_valid", valid, 0);
            check("rst_data", data, 0);
            check("rst_last", last, 0);
            check("rst_frame_cnt", fcnt_o, 0);
            check("rst_busy", busy, 0);
            pop_s = 0;
            rd_s = 0;
            prev_stall = 0;
        end else begin
            ev = (outst - int'(last_rd)) > 0;
            ep = ev & ready;
            er = !empty && (outst - int'(ep) < 2);
            check("valid", valid, ev);
            check("busy", busy, outst > 0);
            check("rd_en", rd_en, er);
            check("rd_en_while_empty", rd_en & empty, 0);
            check("outstanding_le_2", outst <= 2, 1);
            check("frame_cnt", fcnt_o, mcnt);
            if (ev) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    head = exp_q[0];
                    check("data", data, head);
                    check("last", last, head[31]);
                end
            end
            if (prev_stall) begin
                check("stall_valid_held", valid, 1);
                check("stall_data_held", data, held);
            end
            prev_stall = valid & ~ready;
            held = data;
            pop_s = valid & ready;
            rd_s = rd_en;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < outst; i++) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            outst = 0;
            last_rd = 0;
            mcnt = 0;
        end else begin
            if (pop_s) begin
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    if (head[31]) mcnt = (mcnt + 1) % 4;
                end
            end
            outst = outst + int'(rd_s) - int'(pop_s);
            last_rd = rd_s;
        end
    end

    // Directed stimulus and observation.
    logic [31:0] wq [$];
    logic [31:0] beat_data [$];
    int          beat_cyc [$];
    int          cyc = 0;
    int          rd_pulses = 0;
    int          first_rd = -1;
    int          first_v = -1;
    bit          fmode = 0;
    int          fi = 0;
    int          fexp [5] = '{1, 2, 3, 0, 1};

    task automatic clear_stats();
        cyc = 0;
        rd_pulses = 0;
        first_rd = -1;
        first_v = -1;
        beat_data.delete();
        beat_cyc.delete();
    endtask

    task automatic run(input int n, input bit rnd, input int wprob);
        bit lastpop;
        for (int k = 0; k < n; k++) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            if (wq.size() > 0 && fcnt < 16 && $urandom_range(0, 99) < wprob) begin
                wr_en = 1'b1;
                wr_data = wq.pop_front();
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (rd_en) begin
                rd_pulses++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (valid && first_v < 0) first_v = cyc;
            lastpop = valid & ready & last;
            if (valid & ready) begin
                beat_data.push_back(data);
                beat_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (lastpop && fmode) begin
                if (fi < 5) check("frame_cnt_step", fcnt_o, fexp[fi]);
                else check("frame_cnt_extra", fi, 4);
                fi++;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int len [5] = '{1, 2, 3, 1, 2};
        int w;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_valid", valid, 0);
        check("post_reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // Streaming 0x1..0x10.
        ready = 1'b1;
        for (int i = 1; i <= 16; i++) wq.push_back(32'(i));
        clear_stats();
        run(30, 0, 100);
        check("stream_latency", first_v - first_rd, 2);
        check("stream_beats", beat_data.size(), 16);
        for (int i = 0; i < 16 && i < beat_data.size(); i++)
            check("stream_word", beat_data[i], 32'(i + 1));
        if (beat_cyc.size() == 16) check("stream_no_gaps", beat_cyc[15] - beat_cyc[0], 15);

        // Stall with 8 queued words.
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) wq.push_back(32'(i));
        clear_stats();
        run(10, 0, 100);
        check("stall_rd_pulses", rd_pulses, 2);
        check("stall_head_valid", valid, 1);
        check("stall_head_data", data, 32'h1);
        check("stall_fifo_count", fcnt, 6);
        ready = 1'b1;
        clear_stats();
        run(20, 0, 100);
        check("release_beats", beat_data.size(), 8);
        for (int i = 0; i < 8 && i < beat_data.size(); i++)
            check("release_word", beat_data[i], 32'(i + 1));
        check("release_rd_pulses", rd_pulses, 6);
        check("release_fifo_count", fcnt, 0);

        // Single word into an empty FIFO.
        wq.push_back(32'hA5);
        clear_stats();
        run(8, 0, 100);
        check("single_rd_pulses", rd_pulses, 1);
        check("single_beats", beat_data.size(), 1);
        if (beat_data.size() > 0) check("single_word", beat_data[0], 32'hA5);

        // Reset with two words buffered.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) wq.push_back(32'h11 + 32'(i));
        clear_stats();
        run(6, 0, 100);
        check("pre_reset_fifo_count", fcnt, 2);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midburst_rst_valid", valid, 0);
        check("midburst_rst_busy", busy, 0);
        check("midburst_rst_data", data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        clear_stats();
        run(10, 0, 100);
        check("post_rst_beats", beat_data.size(), 2);
        if (beat_data.size() == 2) begin
            check("post_rst_word0", beat_data[0], 32'h13);
            check("post_rst_word1", beat_data[1], 32'h14);
        end

        // Random ready and writes.
        for (int i = 0; i < 10000; i++) wq.push_back($urandom);
        budget = 0;
        while ((wq.size() > 0 || exp_q.size() > 0 || busy) && budget < 60000) begin
            clear_stats();
            run(1, 1, 75);
            budget++;
        end
        check("random_drained", exp_q.size(), 0);
        check("random_in_budget", budget < 60000, 1);

        // Framing: five frames, counter wraps at 4.
        ready = 1'b1;
        pulse_reset();
        fmode = 1;
        fi = 0;
        w = 0;
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < len[f]; j++) begin
                wq.push_back((j == len[f] - 1) ? (32'h8000_0200 + 32'(w)) : (32'h200 + 32'(w)));
                w++;
            end
        end
        clear_stats();
        run(30, 0, 100);
        check("frames_seen", fi, 5);
        check("frame_cnt_final", fcnt_o, 1);
        check("frame_beats", beat_data.size(), 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
